// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding,
// counter sizing and the WIDTH/CHUNK legality rule.
package seq_chunk_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Chunk counter width: clog2 of the chunk count, never below one bit.
   function automatic int cnt_width(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

   // Chunk size must be positive and split the operand width evenly.
   function automatic bit chunk_fits(input int width, input int chunk);
      return (width >= 1) && (chunk >= 1) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/seq_chunk_adder_ripple.sv
// Combinational CHUNK-bit ripple-carry adder slice. Also exposes the carry
// into its top bit so the parent can derive signed overflow.
module chunk_ripple_adder #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             c,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] cy;

   // Full-adder chain, LSB first.
   always_comb begin
      cy    = '0;
      s     = '0;
      cy[0] = c;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]    = x[i] ^ y[i] ^ cy[i];
         cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
      end
      co    = cy[CHUNK];
      c_msb = cy[CHUNK-1];
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands are consumed CHUNK bits per
// clock through a registered carry. Subtraction reuses the adder as
// A + ~B + ~cin, so cout=1 in subtract mode means "no borrow".
module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = cnt_width(NCHUNK);

   if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
      $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
   end

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   res_sh;
   logic [WIDTH-1:0]   res_next;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CHUNK-1:0]   ch_s;
   logic               ch_co;
   logic               ch_cmsb;
   logic               last;

   chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
      .x     (op_a[CHUNK-1:0]),
      .y     (op_b[CHUNK-1:0]),
      .c     (carry_q),
      .s     (ch_s),
      .co    (ch_co),
      .c_msb (ch_cmsb)
   );

   assign last = (cnt_q == CNT_W'(NCHUNK - 1));

   // Result register shifts right; each new chunk enters at the top.
   always_comb begin
      res_next                    = res_sh >> CHUNK;
      res_next[WIDTH-1 -: CHUNK]  = ch_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand/carry/result datapath; outputs only update on the final chunk.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a    <= '0;
         op_b    <= '0;
         res_sh  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_a    <= a;
                  op_b    <= sub ? ~b : b;
                  carry_q <= cin ^ sub;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               op_a    <= op_a >> CHUNK;
               op_b    <= op_b >> CHUNK;
               res_sh  <= res_next;
               carry_q <= ch_co;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last) begin
                  sum  <= res_next;
                  cout <= ch_co;
                  ovf  <= ch_cmsb ^ ch_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK = 2, 16, 1) share the
// same stimulus and are compared against an integer-arithmetic model.
module tb_seq_chunk_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cin;
   logic        sub;
   logic [15:0] a;
   logic [15:0] b;

   logic        in_ready_d  [3];
   logic        out_valid_d [3];
   logic [15:0] sum_d       [3];
   logic        cout_d      [3];
   logic        ovf_d       [3];

   int total = 0;
   int bad   = 0;
   int lat_exp [3];

   always #5 clk = ~clk;

   seq_chunk_adder #(.WIDTH(16), .CHUNK(2)) u_c2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[0]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[0]),
      .out_ready(out_ready), .sum(sum_d[0]), .cout(cout_d[0]), .ovf(ovf_d[0])
   );

   seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[1]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[1]),
      .out_ready(out_ready), .sum(sum_d[1]), .cout(cout_d[1]), .ovf(ovf_d[1])
   );

   seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[2]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[2]),
      .out_ready(out_ready), .sum(sum_d[2]), .cout(cout_d[2]), .ovf(ovf_d[2])
   );

   task automatic check(input string tag, input int idx,
                        input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms,
                                 output logic [15:0] s, output logic co,
                                 output logic ov);
      int ua, ub, sa, sb, ci, ru, rs;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      ci = mc ? 1 : 0;
      if (ms) begin
         ru = ua - ub - ci;
         rs = sa - sb - ci;
         co = (ua >= ub + ci);
      end else begin
         ru = ua + ub + ci;
         rs = sa + sb + ci;
         co = (ru > 65535);
      end
      s  = ru[15:0];
      ov = (rs > 32767) || (rs < -32768);
   endfunction

   task automatic check_idle(input string tag, input logic [15:0] es,
                             input logic ec, input logic eo);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_in_ready"},  i, in_ready_d[i],  1);
         check({tag, "_out_valid"}, i, out_valid_d[i], 0);
         check({tag, "_sum"},       i, sum_d[i],       es);
         check({tag, "_cout"},      i, cout_d[i],      ec);
         check({tag, "_ovf"},       i, ovf_d[i],       eo);
      end
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts);
      logic [15:0] es;
      logic        ec, eo;
      int          lat [3];
      bool_wait: begin end
      model(ta, tb, tc, ts, es, ec, eo);
      @(posedge clk); #1;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) lat[i] = -1;
      for (int k = 0; k <= 24; k++) begin
         for (int i = 0; i < 3; i++)
            if (out_valid_d[i] && lat[i] < 0) lat[i] = k;
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
         @(posedge clk); #1;
         // Inputs are scrambled mid-operation; the DUTs must ignore them.
         a = 16'($urandom); b = 16'($urandom);
         cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
         check("latency", i, lat[i], lat_exp[i]);
         check("sum",     i, sum_d[i],  es);
         check("cout",    i, cout_d[i], ec);
         check("ovf",     i, ovf_d[i],  eo);
      end
      // Backpressure: result must hold and no new request may be taken.
      for (int h = 0; h < 5; h++) begin
         @(posedge clk); #1;
         a = 16'($urandom); b = 16'($urandom); in_valid = ~in_valid;
         for (int i = 0; i < 3; i++) begin
            check("hold_sum",       i, sum_d[i],       es);
            check("hold_in_ready",  i, in_ready_d[i],  0);
            check("hold_out_valid", i, out_valid_d[i], 1);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_idle("release", es, ec, eo);
   endtask

   initial begin
      lat_exp[0] = 8;
      lat_exp[1] = 1;
      lat_exp[2] = 16;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_idle("reset", 16'h0000, 1'b0, 1'b0);

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      run_op(16'h0010, 16'h0001, 1'b1, 1'b1);

      // Reset landing in the middle of an operation.
      @(posedge clk); #1;
      a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle("midrst", 16'h0000, 1'b0, 1'b0);
      run_op(16'h0102, 16'h0304, 1'b0, 1'b0);

      for (int r = 0; r < 20; r++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle parametrised adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per clock through a registered ripple carry.
- Successor to the fixed-width combinational full-adder chain: configurable width and chunk size, with a subtract mode and a signed-overflow flag.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 1.
- CHUNK, 2, bits processed per cycle; must be >= 1 and divide WIDTH exactly; violation is an elaboration error.
- NCHUNK, derived = WIDTH/CHUNK, number of processing cycles; not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode) or borrow-in (subtract mode).
- sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB; in subtract mode 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset values: state IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. Internal operand, carry and counter registers are all 0.
- FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, on in_valid=1 (accept edge T):
  - latch A into the operand shift register.
  - latch B into the operand shift register, or ~B when sub=1.
  - set the carry register to cin, or ~cin when sub=1.
  - clear the chunk counter; go to RUN.
- RUN, each cycle:
  - add the low CHUNK bits of both operand registers plus the carry register through the chunk sub-module.
  - shift the chunk result into the top of the result register (LSB chunk first); shift the operands right by CHUNK.
  - register the chunk carry-out; increment the counter.
  - on the NCHUNK-th RUN cycle: register cout, and set ovf = carry-into-MSB XOR carry-out-of-MSB; go to DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge T. NCHUNK=1 (CHUNK=WIDTH) gives a 1-cycle RUN.
- DONE: sum, cout and ovf stay stable while out_valid=1 and out_ready=0. On out_ready=1, return to IDLE next cycle (out_valid=0, in_ready=1).
- sum, cout and ovf keep their last values in IDLE and RUN; only out_valid qualifies them.
- Input changes and in_valid pulses during RUN/DONE are ignored; no queuing.
- Throughput: at most one operation per NCHUNK+2 cycles (accept, NCHUNK RUN, DONE, with immediate out_ready).
- Mid-operation reset has priority over everything else. Any state goes to IDLE with all outputs at reset values on the next edge; the partial result is discarded.
- Width rules: no sign extension. Arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE, RUN, DONE) as named constants.
  - the counter width computed as clog2(NCHUNK), minimum 1.
  - the CHUNK/WIDTH divisibility check.
- Sub-module chunk_ripple_adder (parameter CHUNK), purely combinational:
  - inputs: CHUNK-bit x and y, carry c.
  - outputs: CHUNK-bit s, carry co, and c_msb (carry into its top bit, used for ovf).
  - built as a ripple chain of full adders.

Test Plan:
- Reset, then release -> in_ready=1, out_valid=0, sum=0x0000, cout=0, ovf=0.
- WIDTH=16, CHUNK=2: a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid exactly 8 cycles after accept, sum=0x5555, cout=0, ovf=0.
- Add boundaries:
  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
  - a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- Subtract:
  - a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0001, cin=1 -> sum=0x000E.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b -> sum/cout/ovf stable, in_ready=0, no new op accepted. out_ready=1 -> IDLE next cycle.
- rst pulsed on RUN cycle 3 -> next edge IDLE, out_valid=0, sum=0. A following op a=0x0102, b=0x0304 yields 0x0406. Repeat the add checks with CHUNK=16 (latency 1) and CHUNK=1 (latency 16).
